// File: rtl/irda_sip_sched.sv
// SIP scheduler for the FIR/MIR path: decides when a Serial Infrared
// Interaction Pulse is due, handshakes with the SIP generator and holds off
// the frame transmitter so a SIP and a frame never overlap.
module irda_sip_sched #(
  parameter int unsigned CNT_W   = 24,
  parameter int unsigned TIMEOUT = 511,
  parameter int unsigned TO_W    = 10
) (
  input  logic             clk,
  input  logic             wb_rst_i,
  input  logic             fast_enable,
  input  logic [CNT_W-1:0] sip_period,
  input  logic             sip_force,
  input  logic             sip_after_frame,
  input  logic             tx_frame_end,
  input  logic             tx_busy,
  input  logic             sip_end_i,
  output logic             sip_o,
  output logic             tx_hold,
  output logic             sip_active,
  output logic             sip_done,
  output logic             sip_timeout
);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    REQ      = 2'd1,
    END_WAIT = 2'd2
  } state_t;

  localparam logic [TO_W-1:0] GUARD_MAX = TO_W'(TIMEOUT);

  state_t            state;
  logic              pending;
  logic              fe_q;
  logic [CNT_W-1:0]  cnt;
  logic [TO_W-1:0]   guard;

  logic fe_rise;
  logic period_on;
  logic interval_hit;
  logic event_hit;

  // Event decode: the counter hits zero on the cycle it steps 1 -> 0 or while it rests at 0
  always_comb begin
    fe_rise      = fast_enable & ~fe_q;
    period_on    = (sip_period != '0);
    interval_hit = fast_enable & period_on & ~fe_rise & (cnt <= CNT_W'(1));
    event_hit    = sip_force | (tx_frame_end & sip_after_frame) | interval_hit;
  end

  // Transmitter hold and activity are pure decodes of registered state
  assign tx_hold    = pending | (state != IDLE);
  assign sip_active = (state != IDLE);

  // Scheduler FSM, interval counter and guard timer
  always_ff @(posedge clk) begin
    if (wb_rst_i) begin
      state       <= IDLE;
      pending     <= 1'b0;
      fe_q        <= 1'b0;
      cnt         <= '0;
      guard       <= '0;
      sip_o       <= 1'b0;
      sip_done    <= 1'b0;
      sip_timeout <= 1'b0;
    end else begin
      fe_q        <= fast_enable;
      sip_done    <= 1'b0;
      sip_timeout <= 1'b0;
      case (state)
        IDLE: begin
          if (fe_rise) begin
            cnt <= sip_period;
          end else if (fast_enable && period_on && (cnt != '0)) begin
            cnt <= cnt - CNT_W'(1);
          end
          if (!fast_enable) begin
            pending <= 1'b0;
          end else if (pending && !tx_busy) begin
            state   <= REQ;
            sip_o   <= 1'b1;
            pending <= 1'b0;
            guard   <= '0;
          end else if (event_hit) begin
            pending <= 1'b1;
          end
        end
        REQ: begin
          if (sip_end_i) begin
            state <= END_WAIT;
            sip_o <= 1'b0;
            guard <= '0;
          end else if (guard == GUARD_MAX) begin
            state       <= IDLE;
            sip_o       <= 1'b0;
            sip_timeout <= 1'b1;
            cnt         <= sip_period;
          end else begin
            guard <= guard + TO_W'(1);
          end
        end
        END_WAIT: begin
          if (!sip_end_i) begin
            state    <= IDLE;
            sip_done <= 1'b1;
            cnt      <= sip_period;
          end else if (guard == GUARD_MAX) begin
            state       <= IDLE;
            sip_timeout <= 1'b1;
            cnt         <= sip_period;
          end else begin
            guard <= guard + TO_W'(1);
          end
        end
        default: begin
          state <= IDLE;
          sip_o <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_irda_sip_sched.sv
// Directed bench for irda_sip_sched with a behavioural SIP generator and an
// event scoreboard for sip_done / sip_timeout pulses.
module tb_irda_sip_sched;

  localparam int unsigned CNT_W    = 24;
  localparam int unsigned TIMEOUT  = 511;
  localparam int unsigned TO_W     = 10;
  localparam int          GEN_RISE = 350;
  localparam int          GEN_LEN  = 20;
  localparam int          EV_DONE  = 1;
  localparam int          EV_TO    = 2;

  logic             clk = 1'b0;
  logic             wb_rst_i;
  logic             fast_enable;
  logic [CNT_W-1:0] sip_period;
  logic             sip_force;
  logic             sip_after_frame;
  logic             tx_frame_end;
  logic             tx_busy;
  logic             sip_end_i;
  logic             sip_o;
  logic             tx_hold;
  logic             sip_active;
  logic             sip_done;
  logic             sip_timeout;

  int checks = 0;
  int errors = 0;
  int exp_q[$];
  int rise_cnt = 0;
  logic sip_o_prev = 1'b0;

  logic gen_en = 1'b0;
  logic gen_busy = 1'b0;
  logic gen_sip_q = 1'b0;
  int   gen_cnt = 0;

  irda_sip_sched #(
    .CNT_W  (CNT_W),
    .TIMEOUT(TIMEOUT),
    .TO_W   (TO_W)
  ) dut (
    .clk            (clk),
    .wb_rst_i       (wb_rst_i),
    .fast_enable    (fast_enable),
    .sip_period     (sip_period),
    .sip_force      (sip_force),
    .sip_after_frame(sip_after_frame),
    .tx_frame_end   (tx_frame_end),
    .tx_busy        (tx_busy),
    .sip_end_i      (sip_end_i),
    .sip_o          (sip_o),
    .tx_hold        (tx_hold),
    .sip_active     (sip_active),
    .sip_done       (sip_done),
    .sip_timeout    (sip_timeout)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic logic get_sig(input int which);
    case (which)
      0:       return sip_o;
      1:       return sip_active;
      2:       return sip_end_i;
      3:       return sip_done;
      default: return tx_hold;
    endcase
  endfunction

  // Bounded wait; the final compare fails if the bound expires
  task automatic wait_sig(input string tag, input int which, input logic val,
                          input int max, output int n);
    n = 0;
    while (n < max) begin
      @(posedge clk); #1;
      n++;
      if (get_sig(which) === val) break;
    end
    chk(tag, 32'(get_sig(which)), 32'(val));
  endtask

  task automatic tick(input int k);
    repeat (k) begin
      @(posedge clk); #1;
    end
  endtask

  // Behavioural SIP generator: raises sip_end_i GEN_RISE cycles after a sip_o rise, holds GEN_LEN cycles
  always @(posedge clk) begin
    gen_sip_q <= sip_o;
    if (!gen_en) begin
      sip_end_i <= 1'b0;
      gen_busy  <= 1'b0;
    end else if (!gen_busy && sip_o === 1'b1 && gen_sip_q === 1'b0) begin
      gen_busy <= 1'b1;
      gen_cnt  <= 0;
    end else if (gen_busy) begin
      gen_cnt <= gen_cnt + 1;
      if (gen_cnt == GEN_RISE) sip_end_i <= 1'b1;
      if (gen_cnt == GEN_RISE + GEN_LEN) begin
        sip_end_i <= 1'b0;
        gen_busy  <= 1'b0;
      end
    end
  end

  // Output monitor: counts sip_o rises and scores completion/abort pulses
  always @(negedge clk) begin
    sip_o_prev <= sip_o;
    if (wb_rst_i === 1'b0) begin
      if (sip_o === 1'b1 && sip_o_prev === 1'b0) rise_cnt <= rise_cnt + 1;
      if (sip_done === 1'b1 || sip_timeout === 1'b1) begin
        chk("done_and_timeout_exclusive", 32'(sip_done & sip_timeout), 32'd0);
        if (exp_q.size() == 0) chk("sb_unexpected_event", sip_timeout ? EV_TO : EV_DONE, 0);
        else chk("sb_event", sip_timeout ? EV_TO : EV_DONE, exp_q.pop_front());
      end
    end
  end

  initial begin
    int n;
    int hi;
    int viol;
    int rises0;

    wb_rst_i        = 1'b1;
    fast_enable     = 1'b0;
    sip_period      = '0;
    sip_force       = 1'b0;
    sip_after_frame = 1'b0;
    tx_frame_end    = 1'b0;
    tx_busy         = 1'b0;
    sip_end_i       = 1'b0;

    // Reset state
    tick(3);
    chk("reset_outputs", 32'({sip_o, tx_hold, sip_active, sip_done, sip_timeout}), 32'd0);
    wb_rst_i = 1'b0;
    tick(2);

    // Periodic SIPs, period 1000, generator connected
    gen_en     = 1'b1;
    sip_period = CNT_W'(1000);
    exp_q.push_back(EV_DONE);
    fast_enable = 1'b1;
    wait_sig("periodic_first_rise", 0, 1'b1, 1100, n);
    chk("periodic_first_latency", n, 1002);
    chk("periodic_hold_during_req", 32'(tx_hold), 32'd1);
    wait_sig("periodic_sip_fall", 0, 1'b0, 600, n);
    chk("periodic_fall_on_end", 32'({sip_end_i, sip_active}), 32'b11);
    wait_sig("periodic_done", 3, 1'b1, 100, n);
    chk("periodic_done_after_end_low", 32'(sip_end_i), 32'd0);
    exp_q.push_back(EV_DONE);
    wait_sig("periodic_second_rise", 0, 1'b1, 1100, n);
    chk("periodic_second_latency", n, 1001);
    sip_period = '0;
    wait_sig("periodic_second_idle", 1, 1'b0, 1200, n);
    tick(3);

    // Tx blocking: force while transmitter busy for 200 cycles
    tx_busy   = 1'b1;
    sip_force = 1'b1;
    exp_q.push_back(EV_DONE);
    tick(1);
    sip_force = 1'b0;
    chk("txblock_hold", 32'({tx_hold, sip_o}), 32'b10);
    viol = 0;
    repeat (200) begin
      tick(1);
      if (sip_o !== 1'b0 || tx_hold !== 1'b1) viol++;
    end
    chk("txblock_no_sip_while_busy", viol, 0);
    tx_busy = 1'b0;
    tick(1);
    chk("txblock_sip_after_busy_falls", 32'(sip_o), 32'd1);
    wait_sig("txblock_idle", 1, 1'b0, 1200, n);
    tick(3);

    // Frame end with and without sip_after_frame
    sip_after_frame = 1'b1;
    tx_frame_end    = 1'b1;
    exp_q.push_back(EV_DONE);
    tick(1);
    tx_frame_end = 1'b0;
    chk("frame_end_pending", 32'(tx_hold), 32'd1);
    wait_sig("frame_end_rise", 0, 1'b1, 3, n);
    chk("frame_end_latency", n, 1);
    wait_sig("frame_end_idle", 1, 1'b0, 1200, n);
    tick(3);
    rises0 = rise_cnt;
    sip_after_frame = 1'b0;
    tx_frame_end    = 1'b1;
    tick(1);
    tx_frame_end = 1'b0;
    tick(20);
    chk("frame_end_disabled_no_sip", rise_cnt - rises0, 0);
    chk("frame_end_disabled_no_hold", 32'(tx_hold), 32'd0);

    // Absorption of events during REQ
    rises0 = rise_cnt;
    sip_after_frame = 1'b1;
    sip_force = 1'b1;
    exp_q.push_back(EV_DONE);
    tick(1);
    sip_force = 1'b0;
    wait_sig("absorb_rise", 0, 1'b1, 3, n);
    tick(5);
    sip_force    = 1'b1;
    tx_frame_end = 1'b1;
    tick(1);
    sip_force    = 1'b0;
    tx_frame_end = 1'b0;
    wait_sig("absorb_idle", 1, 1'b0, 1200, n);
    chk("absorb_pending_clear", 32'(tx_hold), 32'd0);
    tick(30);
    chk("absorb_single_sip", rise_cnt - rises0, 1);
    sip_after_frame = 1'b0;

    // Timeout with generator silent, then reload of the interval counter
    gen_en = 1'b0;
    tick(2);
    exp_q.push_back(EV_TO);
    sip_force = 1'b1;
    tick(1);
    sip_force = 1'b0;
    wait_sig("timeout_rise", 0, 1'b1, 3, n);
    sip_period = CNT_W'(77);
    hi = 0;
    while (sip_o === 1'b1 && hi < 600) begin
      hi++;
      tick(1);
    end
    chk("timeout_sip_high_cycles", hi, TIMEOUT + 1);
    chk("timeout_pulse_and_idle", 32'({sip_timeout, sip_active}), 32'b10);
    exp_q.push_back(EV_TO);
    wait_sig("timeout_reload_rise", 0, 1'b1, 100, n);
    chk("timeout_reload_latency", n, 78);
    sip_period = '0;
    wait_sig("timeout_second_idle", 1, 1'b0, 600, n);
    gen_en = 1'b1;
    tick(3);

    // Reset during END_WAIT
    sip_force = 1'b1;
    tick(1);
    sip_force = 1'b0;
    wait_sig("rst_end_high", 2, 1'b1, 600, n);
    wait_sig("rst_enter_end_wait", 0, 1'b0, 5, n);
    chk("rst_in_end_wait", 32'(sip_active), 32'd1);
    wb_rst_i = 1'b1;
    tick(1);
    chk("rst_outputs_cleared", 32'({sip_o, tx_hold, sip_active, sip_done, sip_timeout}), 32'd0);
    wb_rst_i = 1'b0;
    wait_sig("rst_gen_release", 2, 1'b0, 60, n);
    tick(3);

    // fast_enable dropped during REQ: SIP completes, nothing follows
    rises0 = rise_cnt;
    sip_force = 1'b1;
    exp_q.push_back(EV_DONE);
    tick(1);
    sip_force = 1'b0;
    wait_sig("disable_rise", 0, 1'b1, 3, n);
    fast_enable = 1'b0;
    sip_period  = CNT_W'(50);
    wait_sig("disable_completes", 1, 1'b0, 1200, n);
    sip_force = 1'b1;
    tick(1);
    sip_force = 1'b0;
    tick(100);
    chk("disable_no_new_sip", rise_cnt - rises0, 1);
    chk("disable_no_hold", 32'(tx_hold), 32'd0);

    chk("scoreboard_drained", exp_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/irda_sip_sched.md
Name: irda_sip_sched

Overview:
- Schedules Serial Infrared Interaction Pulses (SIP) for the FIR/MIR path.
- Decides when a SIP is due: periodic interval expiry, end of a transmitted frame, or a software force.
- Drives the request input of the SIP generator and waits for its end-of-SIP signal.
- Holds off the frame transmitter so a SIP and a frame never overlap on the IR output.

Parameters:
- CNT_W, 24, width of the SIP interval counter and of the sip_period input.
- TIMEOUT, 511, maximum cycles to wait for each generator edge (sip_end_i rise, then fall) before aborting.
- TO_W, 10, width of the guard counter; must satisfy 2**TO_W > TIMEOUT.

Ports:
- clk  in  1  block clock
- wb_rst_i  in  1  synchronous active-high reset
- fast_enable  in  1  FIR/MIR mode enable; scheduling runs only while high
- sip_period  in  CNT_W  interval between periodic SIPs in clk cycles; 0 disables periodic SIPs
- sip_force  in  1  one-cycle software request for an immediate SIP
- sip_after_frame  in  1  when high, tx_frame_end schedules a SIP
- tx_frame_end  in  1  one-cycle pulse at the end of a transmitted frame
- tx_busy  in  1  transmitter is currently sending
- sip_end_i  in  1  end-of-SIP level from the SIP generator
- sip_o  out  1  SIP request level to the generator (generator triggers on its rising edge)
- tx_hold  out  1  transmitter must not start a new frame
- sip_active  out  1  SIP sequence in progress (state != IDLE)
- sip_done  out  1  one-cycle pulse when a SIP completes normally
- sip_timeout  out  1  one-cycle pulse when a SIP sequence is aborted

Behaviour:
Clocking and reset:
- All state updates on posedge clk.
- wb_rst_i is synchronous and has priority over everything else.
- Reset values: state=IDLE, pending=0, interval counter=0, guard counter=0. Outputs sip_o=0, tx_hold=0, sip_active=0, sip_done=0, sip_timeout=0.

Pending flag (set from any of these, only in IDLE with fast_enable=1):
- sip_force=1.
- tx_frame_end=1 while sip_after_frame=1.
- Interval counter reaches 0 while sip_period!=0.
- Events arriving in REQ or END_WAIT are absorbed; they never set pending.

Interval counter:
- Loads sip_period on the rising edge of fast_enable and on every return to IDLE (both normal completion and timeout).
- In IDLE with fast_enable=1 and sip_period!=0: decrements by 1 per cycle while nonzero.
- When it reaches 0 it sets pending and holds at 0.
- Frozen outside IDLE.

fast_enable=0:
- Clears pending and freezes the interval counter.
- A SIP already in REQ/END_WAIT still completes; the generator ignores fast_enable.
- Force and frame-end events are ignored.

States:
- IDLE: when pending=1, fast_enable=1 and tx_busy=0, go to REQ next cycle: sip_o<=1, pending<=0, guard<=0.
- REQ: sip_o held at 1; guard increments each cycle.
  - sip_end_i=1: go to END_WAIT, sip_o<=0, guard<=0.
  - Otherwise, guard==TIMEOUT: go to IDLE, sip_o<=0, sip_timeout pulse.
- END_WAIT: sip_o=0; guard increments.
  - sip_end_i=0: go to IDLE, sip_done pulse.
  - Otherwise, guard==TIMEOUT: go to IDLE, sip_timeout pulse.

Outputs and arbitration:
- tx_hold = pending | (state!=IDLE), decoded only from registers.
- The transmitter finishes its current frame; tx_hold only blocks a new start.
- A SIP is issued the first cycle after tx_busy falls while pending.
- sip_o is always low for at least one cycle between requests, so the generator always sees a rising edge.
- sip_done and sip_timeout are never high in the same cycle.

Test Plan:
- Periodic: fast_enable=1, sip_period=1000, generator connected, tx idle.
  - sip_o rises about 1001 cycles after enable, stays high until sip_end_i rises (~350 cycles later).
  - sip_done fires one cycle after sip_end_i falls; the next sip_o rise comes about 1001 cycles after sip_done.
- Tx blocking: sip_force while tx_busy=1 for 200 cycles.
  - tx_hold=1 from the next cycle; sip_o stays 0 until the cycle after tx_busy falls, then rises.
- Frame end: sip_after_frame=1, tx_frame_end pulse → SIP issued. sip_after_frame=0, same pulse → no SIP.
- Absorption: sip_force and tx_frame_end asserted during REQ → exactly one sip_done, pending=0 afterwards.
- Timeout: sip_end_i tied 0, force SIP.
  - sip_o high for TIMEOUT+1 cycles, then sip_timeout pulse, state IDLE, interval counter reloaded.
- Reset and disable: wb_rst_i during END_WAIT → all outputs 0 on the next cycle. fast_enable=0 during REQ → SIP completes, no new SIP follows.
